// File: rtl/intr_pkg.sv
// Shared constants, state encoding and helpers for the 8080 INTA sequencer.
// Optional RST n decoding is controlled by the RST_DECODE_EN macro.
`timescale 1ns/1ps
package intr_pkg;

    localparam logic [7:0] CALL_OPC_DEF = 8'hCD;
    localparam logic [7:0] RST_MASK     = 8'hC7;
    localparam logic [7:0] RST_MATCH    = 8'hC7;

    localparam logic [7:0] INT0_VEC = 8'h08;
    localparam logic [7:0] INT1_VEC = 8'h18;
    localparam logic [7:0] INT2_VEC = 8'h28;
    localparam logic [7:0] INT3_VEC = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_INVALID,
        CLS_CALL,
        CLS_RST
    } byte_cls_t;

    // RST n jumps to page-zero address n*8.
    function automatic logic [15:0] rst_vector(input logic [7:0] opc);
        return {8'h00, 2'b00, opc[5:3], 3'b000};
    endfunction

endpackage

// File: rtl/intr_ack_dec.sv
// First-byte classifier (CALL / RST n / invalid) and service-address assembly.
// RST n is only recognised when RST_DECODE_EN is defined.
`timescale 1ns/1ps
module intr_ack_dec
    import intr_pkg::*;
#(
    parameter logic [7:0] CALL_OPC = CALL_OPC_DEF
) (
    input  logic [7:0]  byte0,
    input  logic [7:0]  byte1,
    input  logic [7:0]  byte2,
    output byte_cls_t   cls,
    output logic [15:0] vec_addr
);

    always_comb begin
        cls      = CLS_INVALID;
        vec_addr = {byte2, byte1};
        if (byte0 == CALL_OPC) begin
            cls = CLS_CALL;
        end
`ifdef RST_DECODE_EN
        else if ((byte0 & RST_MASK) == RST_MATCH) begin
            cls      = CLS_RST;
            vec_addr = rst_vector(byte0);
        end
`else
`endif
    end

endmodule

// File: rtl/intr_ack_seq.sv
// CPU-side 8080 interrupt acknowledge sequencer: runs the INTA read cycles and
// owns INTE. Define RST_DECODE_EN to accept single-byte RST n acknowledges.
`timescale 1ns/1ps
module intr_ack_seq
    import intr_pkg::*;
#(
    parameter int          DATA_LAT = 1,
    parameter logic [7:0]  CALL_OPC = CALL_OPC_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_intr,
    output logic        cpu_inte,
    output logic        cpu_inta,
    output logic        cpu_rd,
    input  logic [7:0]  cpu_inst,
    input  logic        instr_done,
    input  logic        ei_set,
    input  logic        di_clr,
    output logic        ack_busy,
    output logic        vec_valid,
    output logic [15:0] vec_addr,
    output logic        ack_err
);

    localparam logic [2:0] LAT = 3'(DATA_LAT);

    state_t      state_q, state_d;
    logic        inte_q, inte_d;
    logic        inta_q, inta_d;
    logic        rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] vec_q, vec_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  slot0_q, slot0_d;
    logic [7:0]  slot1_q, slot1_d;
    logic [7:0]  slot2_q, slot2_d;

    byte_cls_t   cls;
    logic [15:0] dec_vec;

    intr_ack_dec #(.CALL_OPC(CALL_OPC)) u_dec (
        .byte0    (slot0_q),
        .byte1    (slot1_q),
        .byte2    (slot2_q),
        .cls      (cls),
        .vec_addr (dec_vec)
    );

    always_comb begin
        state_d = state_q;
        inte_d  = inte_q;
        inta_d  = inta_q;
        rd_d    = 1'b0;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        vec_d   = vec_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        slot2_d = slot2_q;

        // EI/DI are frozen while a sequence owns the flag; DI wins a tie.
        if (!busy_q) begin
            if (di_clr) begin
                inte_d = 1'b0;
            end else if (ei_set) begin
                inte_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (instr_done && cpu_intr && inte_q) begin
                    state_d = S_STROBE;
                    inte_d  = 1'b0;
                    inta_d  = 1'b1;
                    busy_d  = 1'b1;
                    idx_d   = 2'd0;
                    rd_d    = 1'b1;
                end
            end
            S_STROBE: begin
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    case (idx_q)
                        2'd0:    slot0_d = cpu_inst;
                        2'd1:    slot1_d = cpu_inst;
                        default: slot2_d = cpu_inst;
                    endcase
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                case (idx_q)
                    2'd0: begin
                        if (cls == CLS_CALL) begin
                            idx_d   = 2'd1;
                            rd_d    = 1'b1;
                            state_d = S_STROBE;
                        end else if (cls == CLS_RST) begin
                            vec_d   = dec_vec;
                            valid_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                    2'd1: begin
                        idx_d   = 2'd2;
                        rd_d    = 1'b1;
                        state_d = S_STROBE;
                    end
                    default: begin
                        vec_d   = dec_vec;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                inta_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                inta_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            inte_q  <= 1'b0;
            inta_q  <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            vec_q   <= 16'h0000;
            idx_q   <= 2'd0;
            cnt_q   <= 3'd0;
            slot0_q <= 8'h00;
            slot1_q <= 8'h00;
            slot2_q <= 8'h00;
        end else begin
            state_q <= state_d;
            inte_q  <= inte_d;
            inta_q  <= inta_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            slot2_q <= slot2_d;
        end
    end

    assign cpu_inte  = inte_q;
    assign cpu_inta  = inta_q;
    assign cpu_rd    = rd_q;
    assign ack_busy  = busy_q;
    assign vec_valid = valid_q;
    assign vec_addr  = vec_q;
    assign ack_err   = err_q;

endmodule

// File: tb/tb_intr_ack_seq.sv
// Directed bench for intr_ack_seq: two instances (DATA_LAT 1 and 3) share the
// core-side inputs; each has its own interrupt-controller byte model.
`timescale 1ns/1ps
module tb_intr_ack_seq;

    logic clock = 1'b0;
    logic reset, cpu_intr, instr_done, ei_set, di_clr;

    logic        inte_o [2];
    logic        inta_o [2];
    logic        rd_o   [2];
    logic        busy_o [2];
    logic        vv_o   [2];
    logic        err_o  [2];
    logic [15:0] va_o   [2];
    logic [7:0]  inst_i [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    intr_ack_seq #(.DATA_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .cpu_intr(cpu_intr), .cpu_inte(inte_o[0]),
        .cpu_inta(inta_o[0]), .cpu_rd(rd_o[0]), .cpu_inst(inst_i[0]),
        .instr_done(instr_done), .ei_set(ei_set), .di_clr(di_clr),
        .ack_busy(busy_o[0]), .vec_valid(vv_o[0]), .vec_addr(va_o[0]), .ack_err(err_o[0])
    );

    intr_ack_seq #(.DATA_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .cpu_intr(cpu_intr), .cpu_inte(inte_o[1]),
        .cpu_inta(inta_o[1]), .cpu_rd(rd_o[1]), .cpu_inst(inst_i[1]),
        .instr_done(instr_done), .ei_set(ei_set), .di_clr(di_clr),
        .ack_busy(busy_o[1]), .vec_valid(vv_o[1]), .vec_addr(va_o[1]), .ack_err(err_o[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Controller model: the byte is valid only exactly DATA_LAT cycles after
    // its read strobe; any other cycle shows a junk value.
    logic [7:0] resp [3];
    logic [6:0] pipe [2];
    int         k    [2];

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) pipe[d] <= '0;
            else       pipe[d] <= {pipe[d][5:0], rd_o[d]};
            if (!inta_o[d])                  k[d] <= 0;
            else if (pipe[d][lat_of(d) - 1]) k[d] <= k[d] + 1;
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            inst_i[d] = 8'hA5;
            if (pipe[d][lat_of(d) - 1] && k[d] < 3) inst_i[d] = resp[k[d]];
        end
    end

    int          rd_n   [2];
    int          rd_c   [2][3];
    int          vv_n   [2];
    int          vv_c   [2];
    int          err_n  [2];
    int          err_c  [2];
    int          fall_c [2];
    bit          gap    [2];
    logic [15:0] va_at  [2];

    // Records strobes, pulses and INTA shape for ncyc cycles after a start.
    task automatic observe(input int ncyc, input int ei_at, input int drop_at);
        for (int d = 0; d < 2; d++) begin
            rd_n[d] = 0; vv_n[d] = 0; vv_c[d] = 0; err_n[d] = 0; err_c[d] = 0;
            fall_c[d] = 0; gap[d] = 1'b0; va_at[d] = 16'hxxxx;
            for (int j = 0; j < 3; j++) rd_c[d][j] = 0;
        end
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (rd_o[d] === 1'b1) begin
                    if (rd_n[d] < 3) rd_c[d][rd_n[d]] = i;
                    rd_n[d]++;
                end
                if (vv_o[d] === 1'b1) begin vv_n[d]++; vv_c[d] = i; va_at[d] = va_o[d]; end
                if (err_o[d] === 1'b1) begin err_n[d]++; err_c[d] = i; end
                if (inta_o[d] !== 1'b1 && fall_c[d] == 0) fall_c[d] = i;
                else if (inta_o[d] === 1'b1 && fall_c[d] != 0) gap[d] = 1'b1;
            end
            instr_done = 1'b0;
            ei_set     = (i == ei_at);
            if (i == drop_at) cpu_intr = 1'b0;
        end
        ei_set = 1'b0;
    endtask

    task automatic pulse_ei();
        ei_set = 1'b1;
        @(negedge clock);
        ei_set = 1'b0;
    endtask

    task automatic start_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        resp[0] = b0; resp[1] = b1; resp[2] = b2;
        instr_done = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({inte_o[d], inta_o[d], rd_o[d], busy_o[d], vv_o[d], err_o[d]} !== 6'b0) begin
                n_err++;
                $display("[TB] FAIL reset_flags[%0d]: got %b, want 000000", d,
                         {inte_o[d], inta_o[d], rd_o[d], busy_o[d], vv_o[d], err_o[d]});
            end
            n_cmp++;
            if (va_o[d] !== 16'h0000) begin
                n_err++;
                $display("[TB] FAIL reset_vec[%0d]: got %h, want 0000", d, va_o[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_inte_rules();
        logic want [4];
        want[0] = 1'b1; want[1] = 1'b0; want[2] = 1'b1; want[3] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            ei_set = (s == 0 || s == 2 || s == 3);
            di_clr = (s == 1 || s == 3);
            @(negedge clock);
            ei_set = 1'b0; di_clr = 1'b0;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (inte_o[d] !== want[s]) begin
                    n_err++;
                    $display("[TB] FAIL inte_step%0d[%0d]: got %b, want %b", s, d, inte_o[d], want[s]);
                end
            end
        end
    endtask

    task automatic test_inte_gate();
        cpu_intr = 1'b1;
        start_seq(8'hCD, 8'h18, 8'h00);
        observe(6, 0, 0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_n[d] !== 0 || gap[d] !== 1'b0 || fall_c[d] !== 1) begin
                n_err++;
                $display("[TB] FAIL gate_no_ack[%0d]: got rd=%0d gap=%0d fall=%0d, want 0/0/1",
                         d, rd_n[d], gap[d], fall_c[d]);
            end
        end
    endtask

    task automatic test_call_seq();
        pulse_ei();
        start_seq(8'hCD, 8'h18, 8'h00);
        observe(22, 0, 0);
        for (int d = 0; d < 2; d++) begin
            int p = lat_of(d) + 2;
            n_cmp++;
            if (rd_n[d] !== 3) begin
                n_err++; $display("[TB] FAIL call_rd_count[%0d]: got %0d, want 3", d, rd_n[d]);
            end
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (rd_c[d][j] !== 1 + j * p) begin
                    n_err++;
                    $display("[TB] FAIL call_rd_cycle%0d[%0d]: got %0d, want %0d", j, d, rd_c[d][j], 1 + j * p);
                end
            end
            n_cmp++;
            if (vv_n[d] !== 1 || vv_c[d] !== 1 + 3 * p) begin
                n_err++;
                $display("[TB] FAIL call_valid[%0d]: got n=%0d at %0d, want 1 at %0d", d, vv_n[d], vv_c[d], 1 + 3 * p);
            end
            n_cmp++;
            if (va_at[d] !== 16'h0018 || va_o[d] !== 16'h0018) begin
                n_err++;
                $display("[TB] FAIL call_vec[%0d]: got %h/%h, want 0018", d, va_at[d], va_o[d]);
            end
            n_cmp++;
            if (fall_c[d] !== 2 + 3 * p || gap[d] !== 1'b0 || err_n[d] !== 0) begin
                n_err++;
                $display("[TB] FAIL call_inta[%0d]: got fall=%0d gap=%0d err=%0d, want %0d/0/0",
                         d, fall_c[d], gap[d], err_n[d], 2 + 3 * p);
            end
            n_cmp++;
            if (inte_o[d] !== 1'b0) begin
                n_err++; $display("[TB] FAIL call_inte[%0d]: got %b, want 0", d, inte_o[d]);
            end
        end
    endtask

    // First byte FF; EI on the start cycle and again mid-sequence must not set INTE.
    task automatic test_abort_inte_start();
        pulse_ei();
        start_seq(8'hFF, 8'h00, 8'h00);
        ei_set = 1'b1;
        observe(12, 3, 0);
        for (int d = 0; d < 2; d++) begin
            int p = lat_of(d) + 2;
            n_cmp++;
            if (rd_n[d] !== 1 || rd_c[d][0] !== 1) begin
                n_err++; $display("[TB] FAIL ff_rd[%0d]: got n=%0d at %0d, want 1 at 1", d, rd_n[d], rd_c[d][0]);
            end
            n_cmp++;
            if (fall_c[d] !== 2 + p || gap[d] !== 1'b0) begin
                n_err++; $display("[TB] FAIL ff_inta[%0d]: got fall=%0d gap=%0d, want %0d/0", d, fall_c[d], gap[d], 2 + p);
            end
            n_cmp++;
            if (inte_o[d] !== 1'b0) begin
                n_err++; $display("[TB] FAIL ff_inte[%0d]: got %b, want 0", d, inte_o[d]);
            end
`ifdef RST_DECODE_EN
            n_cmp++;
            if (err_n[d] !== 0 || vv_n[d] !== 1 || vv_c[d] !== 1 + p) begin
                n_err++;
                $display("[TB] FAIL ff_rst_pulse[%0d]: got err=%0d vv=%0d at %0d, want 0/1 at %0d",
                         d, err_n[d], vv_n[d], vv_c[d], 1 + p);
            end
            n_cmp++;
            if (va_at[d] !== 16'h0038 || va_o[d] !== 16'h0038) begin
                n_err++; $display("[TB] FAIL ff_rst_vec[%0d]: got %h/%h, want 0038", d, va_at[d], va_o[d]);
            end
`else
            n_cmp++;
            if (err_n[d] !== 1 || err_c[d] !== 1 + p || vv_n[d] !== 0) begin
                n_err++;
                $display("[TB] FAIL ff_abort[%0d]: got err=%0d at %0d vv=%0d, want 1 at %0d, 0",
                         d, err_n[d], err_c[d], vv_n[d], 1 + p);
            end
            n_cmp++;
            if (va_o[d] !== 16'h0018) begin
                n_err++; $display("[TB] FAIL ff_vec_hold[%0d]: got %h, want 0018", d, va_o[d]);
            end
`endif
        end
    endtask

    task automatic test_intr_drop();
        pulse_ei();
        start_seq(8'hCD, 8'h34, 8'h12);
        observe(22, 0, 2);
        cpu_intr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            int p = lat_of(d) + 2;
            n_cmp++;
            if (rd_n[d] !== 3 || vv_n[d] !== 1 || va_at[d] !== 16'h1234) begin
                n_err++;
                $display("[TB] FAIL drop_vec[%0d]: got rd=%0d vv=%0d vec=%h, want 3/1/1234", d, rd_n[d], vv_n[d], va_at[d]);
            end
            n_cmp++;
            if (fall_c[d] !== 2 + 3 * p || gap[d] !== 1'b0) begin
                n_err++; $display("[TB] FAIL drop_inta[%0d]: got fall=%0d gap=%0d, want %0d/0", d, fall_c[d], gap[d], 2 + 3 * p);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_ei();
        start_seq(8'hCD, 8'h18, 8'h00);
        observe(5, 0, 0);
        n_cmp++;
        if (rd_n[0] !== 2) begin
            n_err++; $display("[TB] FAIL mid_two_strobes: got %0d, want 2", rd_n[0]);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({inte_o[d], inta_o[d], rd_o[d], busy_o[d], vv_o[d], err_o[d]} !== 6'b0 || va_o[d] !== 16'h0000) begin
                n_err++;
                $display("[TB] FAIL mid_reset[%0d]: got flags=%b vec=%h, want 000000/0000", d,
                         {inte_o[d], inta_o[d], rd_o[d], busy_o[d], vv_o[d], err_o[d]}, va_o[d]);
            end
        end
        observe(5, 0, 0);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_n[d] !== 0 || fall_c[d] !== 1 || gap[d] !== 1'b0) begin
                n_err++; $display("[TB] FAIL mid_idle[%0d]: got rd=%0d fall=%0d, want 0/1", d, rd_n[d], fall_c[d]);
            end
        end
        pulse_ei();
        start_seq(8'hCD, 8'h28, 8'h00);
        observe(22, 0, 0);
        for (int d = 0; d < 2; d++) begin
            int p = lat_of(d) + 2;
            n_cmp++;
            if (rd_n[d] !== 3 || vv_c[d] !== 1 + 3 * p || va_at[d] !== 16'h0028) begin
                n_err++;
                $display("[TB] FAIL mid_restart[%0d]: got rd=%0d vv@%0d vec=%h, want 3/%0d/0028",
                         d, rd_n[d], vv_c[d], va_at[d], 1 + 3 * p);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cpu_intr = 1'b0; instr_done = 1'b0; ei_set = 1'b0; di_clr = 1'b0;
        resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00;
        @(negedge clock);
        test_reset();
        test_inte_rules();
        test_inte_gate();
        test_call_seq();
        test_abort_inte_start();
        test_intr_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
